// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte over the open-drain PS2_CLK/PS2_DAT lines. The frame
// is start(0), data[7:0] LSB first, odd parity, stop(1). The device ACK is
// sampled on the 11th device-generated falling clock edge.
module ps2_host_tx #(
    parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
    parameter int unsigned INHIBIT_US       = 100,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned FRAME_TIMEOUT_US = 2000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned CYC_PER_US  = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
    localparam int unsigned START_CYC   = CYC_PER_US * START_TIMEOUT_US;
    localparam int unsigned FRAME_CYC   = CYC_PER_US * FRAME_TIMEOUT_US;
    localparam int unsigned PH_MAX      = (START_CYC > INHIBIT_CYC) ? START_CYC : INHIBIT_CYC;
    localparam int unsigned PH_W        = $clog2(PH_MAX + 1);
    localparam int unsigned FR_W        = $clog2(FRAME_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_WAIT_IDLE,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] ph_cnt_q, ph_cnt_d;
    logic [FR_W-1:0] fr_cnt_q, fr_cnt_d;
    logic [9:0]      shift_q, shift_d;
    logic            cur_bit_q, cur_bit_d;
    logic [3:0]      idx_q, idx_d;

    logic clk_s1_q, clk_s2_q, clk_prev_q, fall_q;
    logic dat_s1_q, dat_s2_q;

    // Synchronise the raw lines and register device clock falling edges.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            fall_q     <= clk_prev_q & ~clk_s2_q;
            dat_s1_q   <= ps2_dat_in;
            dat_s2_q   <= dat_s1_q;
        end
    end

    // State, counters and frame shift register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            ph_cnt_q  <= '0;
            fr_cnt_q  <= '0;
            shift_q   <= '1;
            cur_bit_q <= 1'b1;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            ph_cnt_q  <= ph_cnt_d;
            fr_cnt_q  <= fr_cnt_d;
            shift_q   <= shift_d;
            cur_bit_q <= cur_bit_d;
            idx_q     <= idx_d;
        end
    end

    // Next-state logic and line/handshake outputs.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cur_bit_d  = cur_bit_q;
        idx_d      = idx_q;
        tx_ready   = 1'b0;
        busy       = 1'b1;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        tx_done    = 1'b0;
        tx_error   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid) begin
                    shift_d   = {1'b1, ~^tx_data, tx_data};
                    cur_bit_d = 1'b0;
                    idx_d     = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (ph_cnt_q == PH_W'(INHIBIT_CYC - 1)) state_d = S_REQ;
            end
            S_REQ: begin
                // cur_bit_q is the start bit here, so the data line is pulled low.
                ps2_dat_oe = ~cur_bit_q;
                if (fall_q) begin
                    cur_bit_d = shift_q[0];
                    shift_d   = {1'b1, shift_q[9:1]};
                    idx_d     = 4'd1;
                    state_d   = S_SEND;
                end else if (ph_cnt_q == PH_W'(START_CYC - 1)) begin
                    state_d = S_ERROR;
                end
            end
            S_SEND: begin
                ps2_dat_oe = ~cur_bit_q;
                if (fall_q) begin
                    if (idx_q == 4'd10) begin
                        state_d = dat_s2_q ? S_ERROR : S_WAIT_IDLE;
                    end else begin
                        cur_bit_d = shift_q[0];
                        shift_d   = {1'b1, shift_q[9:1]};
                        idx_d     = idx_q + 4'd1;
                    end
                end else if (fr_cnt_q == FR_W'(FRAME_CYC - 1)) begin
                    state_d = S_ERROR;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s2_q && dat_s2_q) begin
                    tx_done = 1'b1;
                    state_d = S_IDLE;
                end else if (fr_cnt_q == FR_W'(FRAME_CYC - 1)) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR: begin
                tx_error = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Phase counter restarts on every state change; frame counter only when
        // the frame begins, so it keeps covering WAIT_IDLE.
        if (state_d != state_q)
            ph_cnt_d = '0;
        else if (ph_cnt_q != PH_W'(PH_MAX))
            ph_cnt_d = ph_cnt_q + PH_W'(1);
        else
            ph_cnt_d = ph_cnt_q;

        if (state_d == S_SEND && state_q != S_SEND)
            fr_cnt_d = '0;
        else if (fr_cnt_q != FR_W'(FRAME_CYC))
            fr_cnt_d = fr_cnt_q + FR_W'(1);
        else
            fr_cnt_d = fr_cnt_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model on wired-AND lines.
// CLK_FREQ_HZ = 1 MHz makes one clock cycle equal one microsecond, so the
// inhibit is 100 cycles, the start timeout 15000 and device clock period 80.
module tb_ps2_host_tx;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic [7:0] tx_data  = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error;
    logic       dev_clk  = 1'b1;
    logic       dev_dat  = 1'b1;
    logic       clk_line, dat_line;

    assign clk_line = dev_clk & ~ps2_clk_oe;
    assign dat_line = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ      (1_000_000),
        .INHIBIT_US       (100),
        .START_TIMEOUT_US (15000),
        .FRAME_TIMEOUT_US (2000)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    int unsigned cyc = 0;
    int unsigned done_cnt = 0, err_cnt = 0, inh_cnt = 0, both_cnt = 0;
    int unsigned t_req = 0, t_err = 0;
    logic        prev_clk_oe = 1'b0;
    logic        handover_ok = 1'b0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Line/pulse monitor sampled on the falling system clock edge.
    always @(negedge CLOCK_50) begin
        if (ps2_clk_oe) inh_cnt <= inh_cnt + 1;
        if (prev_clk_oe && !ps2_clk_oe && resetn) begin
            handover_ok <= ps2_dat_oe;
            t_req       <= cyc;
        end
        prev_clk_oe <= ps2_clk_oe;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt <= err_cnt + 1;
            t_err   <= cyc;
        end
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        chk("ready_before_send", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", tx_ready, 0);
    endtask

    // Device: waits for the request, then generates n_edges clock pulses,
    // sampling the data line in each low phase; ack_bit is driven for the 11th.
    task automatic dev_run(input int n_edges, input logic ack_bit,
                           output logic [9:0] seen, output logic start_low,
                           output logic req_seen);
        seen      = '0;
        start_low = 1'b0;
        req_seen  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLOCK_50);
            if (!ps2_clk_oe && ps2_dat_oe) begin
                req_seen = 1'b1;
                break;
            end
        end
        if (!req_seen) return;
        repeat (20) @(negedge CLOCK_50);
        start_low = ~dat_line;
        for (int k = 0; k < n_edges; k++) begin
            dev_clk = 1'b0;
            repeat (40) @(negedge CLOCK_50);
            if (k < 10) seen[k] = dat_line;
            dev_clk = 1'b1;
            if (k == 9) dev_dat = ack_bit;
            repeat (40) @(negedge CLOCK_50);
            if (k == 10) dev_dat = 1'b1;
        end
    endtask

    task automatic wait_end(input int bound, input int unsigned d0, input int unsigned e0);
        for (int i = 0; i < bound; i++) begin
            @(negedge CLOCK_50);
            if (done_cnt != d0 || err_cnt != e0) break;
        end
        @(negedge CLOCK_50);
    endtask

    task automatic full_send(input string tag, input logic [7:0] b, input logic [9:0] frame_exp);
        int unsigned d0, e0, i0;
        logic [9:0]  seen;
        logic        st, rq;
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
        send(b);
        dev_run(11, 1'b0, seen, st, rq);
        chk({tag, "_req"}, rq, 1);
        chk({tag, "_start_bit_low"}, st, 1);
        chk({tag, "_frame"}, seen, frame_exp);
        chk({tag, "_handover"}, handover_ok, 1);
        chk({tag, "_inhibit_cycles"}, inh_cnt - i0, 100);
        wait_end(200, d0, e0);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_no_error"}, err_cnt - e0, 0);
        chk({tag, "_ready_back"}, tx_ready, 1);
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        int unsigned d0, e0, i0, diff;
        logic [9:0]  seen;
        logic        st, rq;

        // Reset values
        #1;
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_tx_error", tx_error, 0);
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        // 0xED: data 1,0,1,1,0,1,1,1 parity 1 stop 1
        full_send("ed", 8'hED, 10'h3ED);
        // 0x00: parity 1 (line released on the 9th edge)
        full_send("x00", 8'h00, 10'h300);
        // 0x01: parity 0
        full_send("x01", 8'h01, 10'h201);

        // No ACK: device leaves data high on the 11th edge
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED);
        dev_run(11, 1'b1, seen, st, rq);
        wait_end(200, d0, e0);
        chk("nack_error_pulse", err_cnt - e0, 1);
        chk("nack_no_done", done_cnt - d0, 0);
        chk("nack_clk_oe", ps2_clk_oe, 0);
        chk("nack_dat_oe", ps2_dat_oe, 0);
        chk("nack_ready", tx_ready, 1);

        // Start timeout: device never clocks
        d0 = done_cnt; e0 = err_cnt;
        send(8'h3C);
        dev_run(0, 1'b0, seen, st, rq);
        chk("to_req", rq, 1);
        wait_end(16000, d0, e0);
        chk("to_error_pulse", err_cnt - e0, 1);
        chk("to_no_done", done_cnt - d0, 0);
        diff = t_err - t_req;
        chk("to_latency_window", (diff >= 14997 && diff <= 15003), 1);
        chk("to_clk_oe", ps2_clk_oe, 0);
        chk("to_dat_oe", ps2_dat_oe, 0);

        // Reset during inhibit releases the clock line immediately
        send(8'h12);
        repeat (10) @(negedge CLOCK_50);
        chk("inh_clk_oe_high", ps2_clk_oe, 1);
        #2 resetn = 1'b0;
        #1;
        chk("inh_rst_clk_oe", ps2_clk_oe, 0);
        chk("inh_rst_ready", tx_ready, 1);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        // Reset after the 4th data edge of 0xE5 (bit3 = 0, so data is driven)
        send(8'hE5);
        dev_run(4, 1'b0, seen, st, rq);
        chk("mid_dat_oe_high", ps2_dat_oe, 1);
        chk("mid_busy", busy, 1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_clk_oe", ps2_clk_oe, 0);
        chk("mid_rst_dat_oe", ps2_dat_oe, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        chk("mid_ready_after", tx_ready, 1);
        full_send("ff", 8'hFF, 10'h3FF);

        // Request while busy is dropped
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
        send(8'hED);
        repeat (5) @(negedge CLOCK_50);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_run(11, 1'b0, seen, st, rq);
        chk("busy_frame_ed", seen, 10'h3ED);
        wait_end(200, d0, e0);
        repeat (300) @(negedge CLOCK_50);
        chk("busy_one_done", done_cnt - d0, 1);
        chk("busy_no_second_inhibit", inh_cnt - i0, 100);
        chk("busy_idle", busy, 0);

        // Device clocks in IDLE are ignored
        d0 = done_cnt; e0 = err_cnt;
        for (int k = 0; k < 3; k++) begin
            dev_clk = 1'b0;
            repeat (40) @(negedge CLOCK_50);
            dev_clk = 1'b1;
            repeat (40) @(negedge CLOCK_50);
        end
        chk("idle_clk_busy", busy, 0);
        chk("idle_clk_ready", tx_ready, 1);
        chk("idle_clk_dat_oe", ps2_dat_oe, 0);
        chk("idle_clk_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        chk("done_error_exclusive", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
